// File: rtl/imm_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the ID-stage hazard controller.
// Ports: none (opcode constants, extension modes, FSM states, decode helpers).
// Imported by imm_hazard_ctrl and imm_ext_unit.
package imm_hazard_ctrl_pkg;

   // Opcodes the ID stage has to recognise
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [1:0] {
      EXT_ZERO  = 2'b00,
      EXT_SIGN  = 2'b01,
      EXT_UPPER = 2'b10
   } ext_mode_e;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } hz_state_e;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [15:0] imm;
   } instr_t;

   function automatic ext_mode_e decode_ext_mode(input logic [5:0] opcode);
      ext_mode_e mode;
      case (opcode)
         OP_ANDI, OP_ORI, OP_XORI:   mode = EXT_ZERO;
         OP_RTYPE, OP_J, OP_JAL:     mode = EXT_ZERO;
         OP_LUI:                     mode = EXT_UPPER;
         default:                    mode = EXT_SIGN;
      endcase
      return mode;
   endfunction

   // rt is a source only for R-type, branches and stores; elsewhere it is a destination
   function automatic logic reads_rt(input logic [5:0] opcode);
      logic r;
      case (opcode)
         OP_RTYPE, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW: r = 1'b1;
         default:                                        r = 1'b0;
      endcase
      return r;
   endfunction

   // Jumps and LUI carry no rs operand
   function automatic logic reads_rs(input logic [5:0] opcode);
      logic r;
      case (opcode)
         OP_J, OP_JAL, OP_LUI: r = 1'b0;
         default:              r = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/imm_hazard_ctrl_ext.sv
// Immediate extension unit: zero-, sign- or upper-extends the immediate field.
// Ports: imm (DATA_WIDTH) and ext_mode in; ext_imm (EXT_DATA_WIDTH) out.
// Purely combinational; unknown mode encodings yield zero.
module imm_ext_unit
   import imm_hazard_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int EXT_DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0]     imm,
   input  ext_mode_e                 ext_mode,
   output logic [EXT_DATA_WIDTH-1:0] ext_imm
);

   localparam int PAD = EXT_DATA_WIDTH - DATA_WIDTH;

   always_comb begin
      ext_imm = '0;
      case (ext_mode)
         EXT_ZERO:  ext_imm = {{PAD{1'b0}}, imm};
         EXT_SIGN:  ext_imm = {{PAD{imm[DATA_WIDTH-1]}}, imm};
         EXT_UPPER: ext_imm = {imm, {PAD{1'b0}}};
         default:   ext_imm = '0;
      endcase
   end

endmodule

// File: rtl/imm_hazard_ctrl.sv
// ID-stage hazard controller: load-use stall, branch flush and ID/EX immediate register.
// Ports: clk, rst_n; instr_valid, instr, ex_mem_read, ex_rt, branch_taken in;
//        pc_write, ifid_write, ifid_flush, idex_bubble (combinational), imm_out, ext_mode, out_valid (registered) out.
module imm_hazard_ctrl
   import imm_hazard_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int EXT_DATA_WIDTH = 32,
   parameter int STALL_CYCLES   = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      instr_valid,
   input  logic [31:0]               instr,
   input  logic                      ex_mem_read,
   input  logic [4:0]                ex_rt,
   input  logic                      branch_taken,
   output logic                      pc_write,
   output logic                      ifid_write,
   output logic                      ifid_flush,
   output logic                      idex_bubble,
   output logic [EXT_DATA_WIDTH-1:0] imm_out,
   output logic [1:0]                ext_mode,
   output logic                      out_valid
);

   // Counter is preloaded with the number of bubbles still owed after the detect cycle
   localparam logic [2:0] STALL_LOAD  = 3'(STALL_CYCLES - 1);
   localparam logic       STALL_MULTI = (STALL_CYCLES > 1);

   instr_t                    fields;
   ext_mode_e                 mode_dec;
   logic [EXT_DATA_WIDTH-1:0] imm_ext;
   logic                      hazard;

   hz_state_e state, state_nxt;
   logic [2:0] cnt, cnt_nxt;

   assign fields   = instr_t'(instr);
   assign mode_dec = decode_ext_mode(fields.opcode);

   // A register-0 destination never creates a real dependency
   assign hazard = instr_valid & ex_mem_read & (ex_rt != 5'd0) &
                   ((reads_rs(fields.opcode) & (ex_rt == fields.rs)) |
                    (reads_rt(fields.opcode) & (ex_rt == fields.rt)));

   imm_ext_unit #(
      .DATA_WIDTH     (DATA_WIDTH),
      .EXT_DATA_WIDTH (EXT_DATA_WIDTH)
   ) u_imm_ext (
      .imm      (instr[DATA_WIDTH-1:0]),
      .ext_mode (mode_dec),
      .ext_imm  (imm_ext)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
         cnt   <= 3'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;

      if (branch_taken) begin
         // Redirect wins over any stall: the stalled instruction is on the wrong path anyway
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         cnt_nxt     = 3'd0;
         state_nxt   = ST_FLUSH;
      end else begin
         case (state)
            ST_RUN: begin
               if (hazard) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
                  cnt_nxt     = STALL_LOAD;
                  state_nxt   = STALL_MULTI ? ST_STALL : ST_RUN;
               end
            end
            ST_STALL: begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
               // Leave when this decrement lands on zero; a zero count also exits rather than wrapping
               cnt_nxt     = (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
               if (cnt <= 3'd1) begin
                  state_nxt = ST_RUN;
               end
            end
            ST_FLUSH: begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               state_nxt   = ST_RUN;
            end
            default: begin
               state_nxt = ST_RUN;
               cnt_nxt   = 3'd0;
            end
         endcase
      end
   end

   // ID/EX immediate fields; a bubble clears them so EX sees a clean NOP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         imm_out   <= '0;
         ext_mode  <= EXT_ZERO;
      end else if (idex_bubble) begin
         out_valid <= 1'b0;
         imm_out   <= '0;
         ext_mode  <= EXT_ZERO;
      end else begin
         out_valid <= instr_valid;
         imm_out   <= imm_ext;
         ext_mode  <= mode_dec;
      end
   end

endmodule
